// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

endpackage

// File: rtl/uart_tx_frame_baud.sv
// Bit-period timer: loads a divisor, counts down, and flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int unsigned BAUD_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BAUD_W-1:0] div,
  output logic              bit_end
);

  logic [BAUD_W-1:0] cnt;

  // Reload on a new frame or when the current bit period expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || (cnt == '0)) begin
      cnt <= div;
    end else begin
      cnt <= cnt - BAUD_W'(1);
    end
  end

  assign bit_end = (cnt == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_W bits LSB first, optional parity, 1/2 stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BAUD_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trmt,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  output logic              TX,
  output logic              ACK_TRMT,
  output logic              tx_done,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  tx_state_t         state;
  logic [DATA_W-1:0] sh_q;
  logic [BAUD_W-1:0] div_q;
  logic [BAUD_W-1:0] tick_div;
  logic [CNT_W-1:0]  bit_cnt;
  logic              two_q;
  logic              stop_q;
  logic              last_stop;
  logic              accept;
  logic              bit_end;

`ifdef UART_TX_PARITY_EN
  logic              par_en_q;
  logic              par_bit_q;
`else
  logic              unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  // Done and accept are decoded from registered state so a new frame can start with no gap.
  assign last_stop = ~two_q | stop_q;
  assign tx_done   = (state == STOP) & bit_end & last_stop;
  assign accept    = trmt & ((state == IDLE) | tx_done);
  assign ACK_TRMT  = accept;
  assign tick_div  = accept ? baud_div : div_q;

  uart_baud_tick #(.BAUD_W(BAUD_W)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .div     (tick_div),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      TX      <= 1'b1;
      busy    <= 1'b0;
      sh_q    <= '0;
      div_q   <= '0;
      bit_cnt <= '0;
      two_q   <= 1'b0;
      stop_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else if (accept) begin
      state   <= START;
      TX      <= 1'b0;
      busy    <= 1'b1;
      sh_q    <= tx_data;
      div_q   <= baud_div;
      bit_cnt <= '0;
      two_q   <= two_stop;
      stop_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= (parity_mode == PAR_EVEN) | (parity_mode == PAR_ODD);
      par_bit_q <= (parity_mode == PAR_ODD) ? ~^tx_data : ^tx_data;
`endif
    end else if (bit_end) begin
      case (state)
        START: begin
          state   <= DATA;
          TX      <= sh_q[0];
          sh_q    <= sh_q >> 1;
          bit_cnt <= '0;
        end
        DATA: begin
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state <= PARITY;
              TX    <= par_bit_q;
            end else begin
              state <= STOP;
              TX    <= 1'b1;
            end
`else
            state <= STOP;
            TX    <= 1'b1;
`endif
          end else begin
            TX      <= sh_q[0];
            sh_q    <= sh_q >> 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state <= STOP;
          TX    <= 1'b1;
        end
`endif
        STOP: begin
          if (last_stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            stop_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed plan steps plus random traffic vs a frame-window model.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst;
  logic        trmt;
  logic [7:0]  tx_data;
  logic [12:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        TX;
  logic        ACK_TRMT;
  logic        tx_done;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int done_rel = -1;

  // Reference model: the current frame as an accept cycle, a bit list and a bit period.
  int f_start = -1;
  int f_len   = 0;
  int f_per   = 1;
  bit f_bits[$];

  uart_tx_frame #(.DATA_W(8), .BAUD_W(13)) dut (
    .clk         (clk),
    .rst         (rst),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .TX          (TX),
    .ACK_TRMT    (ACK_TRMT),
    .tx_done     (tx_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int frame_bits(input logic [1:0] pm, input bit two);
    int n;
    n = 1 + 8 + (two ? 2 : 1);
`ifdef UART_TX_PARITY_EN
    if (pm == 2'd1 || pm == 2'd2) n++;
`endif
    return n;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic cyc(input bit t, input logic [7:0] d, input logic [12:0] dv,
                     input logic [1:0] pm, input bit two, input bit r);
    bit   in_f, e_done, e_ack;
    logic e_tx;
    trmt = t; tx_data = d; baud_div = dv; parity_mode = pm; two_stop = two; rst = r;
    @(negedge clk);
    in_f   = (f_start >= 0) && (cyc_n > f_start) && (cyc_n <= f_start + f_len);
    e_done = in_f && (cyc_n == f_start + f_len);
    e_tx   = in_f ? f_bits[(cyc_n - f_start - 1) / f_per] : 1'b1;
    e_ack  = t && (!in_f || e_done);
    chk("TX", TX, e_tx);
    chk("tx_done", tx_done, e_done);
    chk("busy", busy, in_f);
    chk("ACK_TRMT", ACK_TRMT, e_ack);
    if (tx_done === 1'b1 && f_start >= 0) done_rel = cyc_n - f_start;
    if (e_ack) begin
      f_bits.delete();
      f_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) f_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
      if (pm == 2'd1) f_bits.push_back(^d);
      if (pm == 2'd2) f_bits.push_back(~^d);
`endif
      f_bits.push_back(1'b1);
      if (two) f_bits.push_back(1'b1);
      f_per   = int'(dv) + 1;
      f_len   = f_bits.size() * f_per;
      f_start = cyc_n;
    end
    if (r) f_start = -1;
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; trmt = 1'b0; tx_data = '0; baud_div = '0; parity_mode = '0; two_stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state and idle line
    repeat (3) cyc(0, 8'h00, 13'd3, 2'd0, 1'b0, 1'b0);

    // 0xA5, no parity, one stop
    done_rel = -1;
    cyc(1, 8'hA5, 13'd3, 2'd0, 1'b0, 1'b0);
    repeat (45) cyc(0, 8'h00, 13'd3, 2'd0, 1'b0, 1'b0);
    chk_int("a5_8n1_done_cycle", done_rel, 40);

    // 0xA5 even then odd parity
    done_rel = -1;
    cyc(1, 8'hA5, 13'd3, 2'd1, 1'b0, 1'b0);
    repeat (48) cyc(0, 8'h00, 13'd3, 2'd0, 1'b0, 1'b0);
    chk_int("a5_even_done_cycle", done_rel, 4 * frame_bits(2'd1, 1'b0));
    done_rel = -1;
    cyc(1, 8'hA5, 13'd3, 2'd2, 1'b0, 1'b0);
    repeat (48) cyc(0, 8'h00, 13'd3, 2'd0, 1'b0, 1'b0);
    chk_int("a5_odd_done_cycle", done_rel, 4 * frame_bits(2'd2, 1'b0));

    // 0x3C with two stop bits
    done_rel = -1;
    cyc(1, 8'h3C, 13'd3, 2'd0, 1'b1, 1'b0);
    repeat (48) cyc(0, 8'h00, 13'd3, 2'd0, 1'b0, 1'b0);
    chk_int("3c_2stop_done_cycle", done_rel, 44);

    // trmt held high: 0x55 then 0xAA back to back
    repeat (40) cyc(1, 8'h55, 13'd3, 2'd0, 1'b0, 1'b0);
    cyc(1, 8'hAA, 13'd3, 2'd0, 1'b0, 1'b0);
    repeat (45) cyc(0, 8'h00, 13'd3, 2'd0, 1'b0, 1'b0);

    // Inputs change mid-frame; next frame uses the new divisor
    cyc(1, 8'hA5, 13'd3, 2'd0, 1'b0, 1'b0);
    repeat (45) cyc(0, 8'hFF, 13'd0, 2'd2, 1'b1, 1'b0);
    done_rel = -1;
    cyc(1, 8'hFF, 13'd0, 2'd0, 1'b0, 1'b0);
    repeat (14) cyc(0, 8'h00, 13'd0, 2'd0, 1'b0, 1'b0);
    chk_int("div0_done_cycle", done_rel, 10);

    // Reset during data bit 3 abandons the frame
    done_rel = -1;
    cyc(1, 8'hA5, 13'd3, 2'd0, 1'b0, 1'b0);
    repeat (13) cyc(0, 8'h00, 13'd3, 2'd0, 1'b0, 1'b0);
    cyc(0, 8'h00, 13'd3, 2'd0, 1'b0, 1'b1);
    repeat (45) cyc(0, 8'h00, 13'd3, 2'd0, 1'b0, 1'b0);
    chk_int("reset_no_done", done_rel, -1);
    cyc(1, 8'h5A, 13'd3, 2'd0, 1'b0, 1'b0);
    repeat (45) cyc(0, 8'h00, 13'd3, 2'd0, 1'b0, 1'b0);
    chk_int("after_reset_done_cycle", done_rel, 40);

    // Random traffic: sparse and held requests with varying settings
    for (int i = 0; i < 2000; i++) begin
      bit t;
      t = (i % 400 < 100) ? 1'b1 : ($urandom_range(0, 7) == 0);
      cyc(t, 8'($urandom), 13'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'b0);
    end
    repeat (60) cyc(0, 8'h00, 13'd3, 2'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit engine, successor to the fixed 8N1 transmitter in the CPU's memory-mapped UART. Serialises one character per handshake with a generic data width, runtime-selectable parity and 1/2 stop bits, and a per-frame latched baud divisor. It supports back-to-back frames with no idle gap. It sits between the UART register/FIFO front-end and the TX pin.

## Interface
- DATA_W, 8: character width in bits, legal 5..9
- BAUD_W, 13: baud divisor width
- clk  in  1  global clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- trmt  in  1  request to send tx_data
- tx_data  in  DATA_W  character, LSB transmitted first
- baud_div  in  BAUD_W  bit period minus one, in clk cycles
- parity_mode  in  2  0/3 = none, 1 = even, 2 = odd
- two_stop  in  1  1 = two stop bits
- TX  out  1  serial line, idles high
- ACK_TRMT  out  1  one-cycle pulse: request accepted, inputs captured
- tx_done  out  1  one-cycle pulse on the last cycle of the final stop bit
- busy  out  1  high from the cycle after accept until the cycle after tx_done

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance:
  - ACK_TRMT = trmt & (state==IDLE | tx_done), combinational, same cycle.
  - On accept, tx_data, baud_div, parity_mode and two_stop are latched, and the FSM enters START.
  - Inputs changing mid-frame have no effect.
- Bit timer:
  - Loaded with the latched divisor at the start of each bit.
  - Decrements each cycle.
  - At 0 the bit ends and the timer reloads.
  - Bit period = divisor+1 cycles; divisor 0 gives 1-cycle bits.
- START: TX=0 for one bit period, then DATA.
- DATA:
  - Shifts out DATA_W bits, LSB first.
  - A bit counter of width $clog2(DATA_W+1) counts 0..DATA_W-1.
  - After the last bit, goes to PARITY if parity is enabled, else STOP.
- PARITY:
  - Even: TX = ^data.
  - Odd: TX = ~^data.
  - One bit period.
- STOP:
  - TX=1 for one bit period, or two if two_stop was latched.
  - tx_done is asserted on the final cycle of STOP; the FSM then returns to IDLE, or to START if a new request is accepted in that cycle.
- Frame length: N = 1 + DATA_W + P + S, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- trmt held high continuously produces continuous frames; ACK_TRMT fires once per frame, coinciding with tx_done.

## Timing
- Reset values: TX=1, ACK_TRMT=0, tx_done=0, busy=0, state IDLE, timer and counters 0.
- Reset asserted mid-frame: the frame is abandoned, TX=1 at the next edge, no tx_done is issued.
- Cycle numbering for one frame:
  - Accept in cycle 0.
  - TX start bit occupies cycles 1..(div+1).
  - Bit k occupies cycles k·(div+1)+1 .. (k+1)·(div+1).
  - tx_done is asserted in cycle N·(div+1).
- TX is registered (no glitches). It changes only on bit boundaries, never mid-bit.
- trmt while busy and not in the tx_done cycle is ignored: no ACK, no queuing.
- In a back-to-back frame, the start bit begins in the cycle after tx_done, so there is zero idle gap.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state and the parity_mode decode are present as described.
- Undefined:
  - The PARITY state and parity logic are removed.
  - parity_mode is ignored (port kept for pin compatibility).
  - Frames are always 1 + DATA_W + S bits.

## Structure
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - parity constants PAR_NONE=2'd0, PAR_EVEN=2'd1, PAR_ODD=2'd2.
- One sub-module, uart_baud_tick:
  - Loads the divisor, counts down, and emits a bit_end pulse.
  - Takes clk, rst, load, div; outputs bit_end.

## Test plan
Common setup: DATA_W=8, div=3 (4 cycles/bit), with trmt pulsed for one cycle unless noted.
- 0xA5, no parity, 1 stop:
  - TX sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - ACK_TRMT in cycle 0; tx_done in cycle 40; busy low from cycle 41.
- 0xA5, even parity, then odd parity:
  - Parity bit is 0 for even, 1 for odd.
  - tx_done in cycle 44.
- 0x3C, no parity, two_stop=1: TX is high for 8 cycles after the data bits; tx_done in cycle 44.
- trmt held high with 0x55 then 0xAA:
  - The second ACK_TRMT coincides with the first tx_done.
  - The second start bit begins in cycle 41 with no idle cycle.
- Change baud_div to 0 and tx_data to 0xFF mid-frame: the current frame keeps 4-cycle bits and data 0xA5; the next frame uses 1-cycle bits.
- Assert rst for one cycle during bit 3: TX=1 on the next cycle, tx_done never pulses, and a fresh trmt is accepted normally afterwards.
